lamp_fpu_log_postnorm: RTL and testbench
========================================

Name: lamp_fpu_log_postnorm

Overview:
- Post-normalisation and rounding stage directly downstream of the bfloat16 log datapath.
- Consumes the log unit's unpacked result {s, e, 12-bit f, isOverflow, isUnderflow, isToRound}.
- Normalises, rounds round-to-nearest-even and packs a 16-bit bfloat16 word.
- Two-stage pipeline with valid/ready handshake and full backpressure support.

Parameters:
- E_DW, 8, exponent width (LAMP_FLOAT_E_DW).
- F_DW, 7, stored fraction width (LAMP_FLOAT_F_DW).
- FTZ, 1, flush subnormal results to signed zero (only value supported).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  input beat valid.
- ready_o  out  1  stage can accept a beat.
- s_i  in  1  result sign.
- e_i  in  E_DW  biased exponent.
- f_i  in  F_DW+5  {ovf bit, hidden bit, fraction[F_DW], guard, round, sticky}.
- isOverflow_i  in  1  upstream overflow: force inf.
- isUnderflow_i  in  1  upstream underflow: force zero.
- isToRound_i  in  1  0 = special value, bypass normalise/round.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- result_o  out  1+E_DW+F_DW  packed {s, e, f}.
- overflow_o  out  1  result saturated to inf.
- underflow_o  out  1  result flushed to zero.
- inexact_o  out  1  rounding discarded nonzero bits.

Behaviour:
- Reset: all stage valids, valid_o, result_o, overflow_o, underflow_o and inexact_o are 0. ready_o = 1 after reset.
- Handshake: a beat transfers on valid_i & ready_o, or on valid_o & ready_i.
- Stage readiness: each stage holds its data while stalled. ready_o = ~s1_valid | (~s2_valid | ready_i).
- Latency: 2 cycles from accept to valid_o with no stall; throughput 1 beat/cycle. Beats stay in order; no beat is dropped or duplicated.
- Stage 1 (normalise), 10-bit signed internal exponent x = e_i:
  - isToRound_i = 0: pass through unchanged and mark bypass.
  - f[11] = 1: shift f right 1, new f[0] = old f[1] | f[0]; x = x + 1.
  - f[11:10] = 00 and f != 0: n = leading zeros of f[10:0]; shift left n; x = x - n.
  - f = 0: mark zero.
- Stage 2 (round/pack):
  - roundUp = f[2] & (f[1] | f[0] | f[3]).
  - m = f[10:3] + roundUp (9 bits). If m[8] = 1: x = x + 1, fraction = 0.
  - inexact_o = |f[2:0] (0 on bypass).
- Stage 2 priority, highest first:
  - bypass: result = {s, e_i, f[9:3]}; no flags.
  - isOverflow_i or x >= 255: {s, 0xFF, 0}, overflow_o = 1.
  - isUnderflow_i, zero, or x <= 0: {s, 0x00, 0}, underflow_o = 1 unless the input f was exactly 0.
  - otherwise: {s, x[7:0], m[6:0]}.
- Output register: holds its value and flags while valid_o & ~ready_i.
- Reset mid-operation: in-flight beats are discarded immediately (async); valid_o falls without waiting for a clock.

Test Plan:
- s=0, e=0x7F, f=01_0000000_000, isToRound=1, ready_i=1 -> result_o=0x3F80 two cycles later, all flags 0.
- RNE rounding, e=0x7F:
  - f=01_0000001_100 -> 0x3F82, inexact=1.
  - f=01_0000000_100 (tie, even) -> 0x3F80, inexact=1.
  - f=01_0000000_101 -> 0x3F81.
- Rounding carry: f=01_1111111_110, e=0x7F -> 0x4000. Overflow bit: f=10_0000000_000, e=0xFE -> 0x7F80, overflow_o=1.
- Normalise left: f=00_0100000_000, e=0x80 -> exponent 0x7E, result 0x3F00. Same f with e=0x02 -> 0x0000, underflow_o=1.
- Bypass: isToRound=0, s=0, e=0xFF, f=01_1000000_000 -> 0x7FC0 (qNaN), no flags; isOverflow_i=1 with s=1 -> 0xFF80.
- Backpressure: hold ready_i=0, present 3 back-to-back beats -> ready_o falls after 2 accepted, valid_o stays high with the first result stable. Raise ready_i -> the 3 results emerge in order.
- Reset asserted with 2 beats in flight -> valid_o=0 immediately.

Source files
------------

// File: rtl/lamp_fpu_log_postnorm.sv
// Post-normalisation, round-to-nearest-even and packing stage for the
// bfloat16 log datapath. Stage 1 normalises the 12-bit working fraction
// and adjusts the exponent. Stage 2 rounds, resolves special cases and
// holds the packed result until the consumer takes it.
module lamp_fpu_log_postnorm #(
  parameter int unsigned E_DW = 8,
  parameter int unsigned F_DW = 7,
  parameter bit          FTZ  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   s_i,
  input  logic [E_DW-1:0]        e_i,
  input  logic [F_DW+4:0]        f_i,
  input  logic                   isOverflow_i,
  input  logic                   isUnderflow_i,
  input  logic                   isToRound_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [E_DW+F_DW:0]     result_o,
  output logic                   overflow_o,
  output logic                   underflow_o,
  output logic                   inexact_o
);

  localparam int unsigned FW     = F_DW + 5;
  localparam int unsigned XW     = E_DW + 2;
  localparam int unsigned LZW    = $clog2(FW);
  localparam int unsigned MAXEXP = (1 << E_DW) - 1;

  logic                r_s1Valid;
  logic                r_s1Sign;
  logic [FW-2:0]       r_s1Frac;
  logic [XW-1:0]       r_s1X;
  logic                r_s1Bypass;
  logic                r_s1FracZero;
  logic                r_s1Ovf;
  logic                r_s1Unf;

  logic                r_s2Valid;
  logic [E_DW+F_DW:0]  r_result;
  logic                r_overflow;
  logic                r_underflow;
  logic                r_inexact;

  logic                w_s1Ready;
  logic                w_s2Ready;
  logic [LZW-1:0]      w_lzc;
  logic                w_found;
  logic [FW-2:0]       w_nF;
  logic [XW-1:0]       w_nX;

  logic                w_roundUp;
  logic                w_carry;
  logic [F_DW-1:0]     w_frac;
  logic [XW-1:0]       w_x;
  logic                w_huge;
  logic                w_tiny;
  logic [E_DW+F_DW:0]  w_nextResult;
  logic                w_nextOvf;
  logic                w_nextUnf;
  logic                w_nextInexact;

  // A stage can take a new beat when it is empty or its contents move on this cycle.
  assign w_s2Ready = ~r_s2Valid | ready_i;
  assign w_s1Ready = ~r_s1Valid | w_s2Ready;
  assign ready_o   = w_s1Ready;

  // Normalise: leading-zero count over f[10:0], then one-bit right shift with sticky fold or left shift by the count.
  always_comb begin
    w_lzc   = '0;
    w_found = 1'b0;
    w_nF    = f_i[FW-2:0];
    w_nX    = {2'b00, e_i};
    for (int i = FW - 2; i >= 0; i--) begin
      if (f_i[i] && !w_found) begin
        w_lzc   = LZW'(FW - 2 - i);
        w_found = 1'b1;
      end
    end
    if (isToRound_i) begin
      if (f_i[FW-1]) begin
        w_nF = {f_i[FW-1:2], f_i[1] | f_i[0]};
        w_nX = w_nX + XW'(1);
      end else if (!f_i[FW-2] && w_found) begin
        w_nF = f_i[FW-2:0] << w_lzc;
        w_nX = w_nX - XW'(w_lzc);
      end
    end
  end

  // Stage 1 register: capture the normalised beat whenever stage 1 is free to advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1Valid    <= 1'b0;
      r_s1Sign     <= 1'b0;
      r_s1Frac     <= '0;
      r_s1X        <= '0;
      r_s1Bypass   <= 1'b0;
      r_s1FracZero <= 1'b0;
      r_s1Ovf      <= 1'b0;
      r_s1Unf      <= 1'b0;
    end else if (w_s1Ready) begin
      r_s1Valid <= valid_i;
      if (valid_i) begin
        r_s1Sign     <= s_i;
        r_s1Frac     <= w_nF;
        r_s1X        <= w_nX;
        r_s1Bypass   <= ~isToRound_i;
        r_s1FracZero <= (f_i == '0);
        r_s1Ovf      <= isOverflow_i;
        r_s1Unf      <= isUnderflow_i;
      end
    end
  end

  // Round to nearest even, propagate mantissa carry into the exponent, then pick bypass/inf/zero/normal.
  always_comb begin
    w_roundUp     = r_s1Frac[2] & (r_s1Frac[1] | r_s1Frac[0] | r_s1Frac[3]);
    w_carry       = (&r_s1Frac[FW-2:3]) & w_roundUp;
    w_frac        = r_s1Frac[F_DW+2:3] + F_DW'(w_roundUp);
    w_x           = r_s1X + XW'(w_carry);
    w_huge        = ~w_x[XW-1] & (w_x >= XW'(MAXEXP));
    w_tiny        = w_x[XW-1] | (w_x == '0);
    w_nextResult  = {r_s1Sign, w_x[E_DW-1:0], w_frac};
    w_nextOvf     = 1'b0;
    w_nextUnf     = 1'b0;
    w_nextInexact = |r_s1Frac[2:0];
    if (r_s1Bypass) begin
      w_nextResult  = {r_s1Sign, r_s1X[E_DW-1:0], r_s1Frac[F_DW+2:3]};
      w_nextInexact = 1'b0;
    end else if (r_s1Ovf || w_huge) begin
      w_nextResult = {r_s1Sign, {E_DW{1'b1}}, {F_DW{1'b0}}};
      w_nextOvf    = 1'b1;
    end else if (r_s1Unf || r_s1FracZero || (FTZ && w_tiny)) begin
      w_nextResult = {r_s1Sign, {E_DW{1'b0}}, {F_DW{1'b0}}};
      w_nextUnf    = ~r_s1FracZero;
    end
  end

  // Output register: load when the consumer is free, otherwise hold result and flags stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2Valid   <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_inexact   <= 1'b0;
    end else if (w_s2Ready) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_result    <= w_nextResult;
        r_overflow  <= w_nextOvf;
        r_underflow <= w_nextUnf;
        r_inexact   <= w_nextInexact;
      end
    end
  end

  assign valid_o     = r_s2Valid;
  assign result_o    = r_result;
  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;
  assign inexact_o   = r_inexact;

endmodule

// File: tb/tb_lamp_fpu_log_postnorm.sv
// Scoreboard bench for lamp_fpu_log_postnorm: the driver pushes the
// hand-computed expected response for each accepted beat, and an
// independent monitor pops and compares on every output transfer.
module tb_lamp_fpu_log_postnorm;

  typedef struct packed {
    logic [15:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
  } expT;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic        s_i;
  logic [7:0]  e_i;
  logic [11:0] f_i;
  logic        isOverflow_i;
  logic        isUnderflow_i;
  logic        isToRound_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] result_o;
  logic        overflow_o;
  logic        underflow_o;
  logic        inexact_o;

  expT sb[$];
  int  checks = 0;
  int  errors = 0;

  lamp_fpu_log_postnorm #(.E_DW(8), .F_DW(7), .FTZ(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .s_i           (s_i),
    .e_i           (e_i),
    .f_i           (f_i),
    .isOverflow_i  (isOverflow_i),
    .isUnderflow_i (isUnderflow_i),
    .isToRound_i   (isToRound_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .result_o      (result_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o),
    .inexact_o     (inexact_o)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the whole run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  // Monitor: sample between edges; a transfer happens at the next rising edge when valid_o and ready_i are both high.
  always @(negedge clk) begin
    expT got;
    expT want;
    #2;
    if (rst && valid_o && ready_i) begin
      checks++;
      got = {result_o, overflow_o, underflow_o, inexact_o};
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpectedBeat got res=%h ovf=%b unf=%b inx=%b", got.res, got.ovf, got.unf, got.inx);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL beat got res=%h ovf=%b unf=%b inx=%b want res=%h ovf=%b unf=%b inx=%b",
                   got.res, got.ovf, got.unf, got.inx, want.res, want.ovf, want.unf, want.inx);
        end
      end
    end
  end

  // Direct comparison used for reset and backpressure observations.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Drive one beat, push its expected response when accepted, bounded wait on ready_o.
  task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [11:0] f,
                               input logic ov, input logic un, input logic tr,
                               input logic [15:0] xRes, input logic xOvf, input logic xUnf, input logic xInx);
    bit accepted = 1'b0;
    @(negedge clk);
    s_i = s; e_i = e; f_i = f;
    isOverflow_i = ov; isUnderflow_i = un; isToRound_i = tr;
    valid_i = 1'b1;
    for (int w = 0; w < 50 && !accepted; w++) begin
      #1;
      if (ready_o) begin
        accepted = 1'b1;
        sb.push_back({xRes, xOvf, xUnf, xInx});
      end
      @(posedge clk);
      #1;
      if (!accepted) @(negedge clk);
    end
    valid_i = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL acceptTimeout got ready_o=0 want ready_o=1 within 50 cycles");
    end
  endtask

  // Wait (bounded) until every expected beat has come out.
  task automatic waitDrain();
    for (int w = 0; w < 50 && sb.size() != 0; w++) @(posedge clk);
    repeat (2) @(posedge clk);
    checkOutput("drain", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    s_i = 1'b0; e_i = '0; f_i = '0;
    isOverflow_i = 1'b0; isUnderflow_i = 1'b0; isToRound_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetValid", valid_o, 0);
    checkOutput("resetResult", result_o, 0);
    checkOutput("resetFlags", {overflow_o, underflow_o, inexact_o}, 0);
    checkOutput("resetReady", ready_o, 1);
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back directed vectors at full throughput.
    applyStimulus(0, 8'h7F, 12'b01_0000000_000, 0, 0, 1, 16'h3F80, 0, 0, 0);
    applyStimulus(0, 8'h7F, 12'b01_0000001_100, 0, 0, 1, 16'h3F82, 0, 0, 1);
    applyStimulus(0, 8'h7F, 12'b01_0000000_100, 0, 0, 1, 16'h3F80, 0, 0, 1);
    applyStimulus(0, 8'h7F, 12'b01_0000000_101, 0, 0, 1, 16'h3F81, 0, 0, 1);
    applyStimulus(0, 8'h7F, 12'b01_1111111_110, 0, 0, 1, 16'h4000, 0, 0, 1);
    applyStimulus(0, 8'hFE, 12'b10_0000000_000, 0, 0, 1, 16'h7F80, 1, 0, 0);
    applyStimulus(0, 8'h80, 12'b00_0100000_000, 0, 0, 1, 16'h3F00, 0, 0, 0);
    applyStimulus(0, 8'h02, 12'b00_0100000_000, 0, 0, 1, 16'h0000, 0, 1, 0);
    applyStimulus(0, 8'hFF, 12'b01_1000000_000, 0, 0, 0, 16'h7FC0, 0, 0, 0);
    applyStimulus(1, 8'h7F, 12'b01_0000000_000, 1, 0, 1, 16'hFF80, 1, 0, 0);
    applyStimulus(0, 8'h7F, 12'b01_0000000_000, 0, 1, 1, 16'h0000, 0, 1, 0);
    applyStimulus(1, 8'h7F, 12'b00_0000000_000, 0, 0, 1, 16'h8000, 0, 0, 0);
    applyStimulus(0, 8'h80, 12'b00_0000001_011, 0, 0, 1, 16'h3CB0, 0, 0, 0);
    applyStimulus(0, 8'hFE, 12'b01_1111111_111, 0, 0, 1, 16'h7F80, 1, 0, 1);
    applyStimulus(1, 8'h00, 12'b00_0000000_000, 0, 0, 0, 16'h8000, 0, 0, 0);
    applyStimulus(0, 8'h01, 12'b01_0000000_000, 0, 0, 1, 16'h0080, 0, 0, 0);
    applyStimulus(0, 8'h7F, 12'b10_0000001_011, 0, 0, 1, 16'h4001, 0, 0, 1);
    waitDrain();

    // Backpressure: consumer stalls while three beats are offered back to back.
    @(negedge clk);
    ready_i = 1'b0;
    fork
      begin
        applyStimulus(0, 8'h7F, 12'b01_0000000_000, 0, 0, 1, 16'h3F80, 0, 0, 0);
        applyStimulus(0, 8'h7F, 12'b01_0000001_100, 0, 0, 1, 16'h3F82, 0, 0, 1);
        applyStimulus(0, 8'h80, 12'b00_0000001_011, 0, 0, 1, 16'h3CB0, 0, 0, 0);
      end
      begin
        repeat (5) @(negedge clk);
        #3;
        checkOutput("stallReady", ready_o, 0);
        checkOutput("stallValid", valid_o, 1);
        checkOutput("stallResult", result_o, 16'h3F80);
        repeat (2) @(negedge clk);
        #3;
        checkOutput("stallHoldValid", valid_o, 1);
        checkOutput("stallHoldResult", result_o, 16'h3F80);
        @(negedge clk);
        ready_i = 1'b1;
      end
    join
    waitDrain();

    // Asynchronous reset with two beats in flight.
    applyStimulus(0, 8'h7F, 12'b01_0000000_000, 0, 0, 1, 16'h3F80, 0, 0, 0);
    applyStimulus(0, 8'h7F, 12'b01_0000001_100, 0, 0, 1, 16'h3F82, 0, 0, 1);
    checkOutput("inFlightValid", valid_o, 1);
    rst = 1'b0;
    #1;
    checkOutput("asyncResetValid", valid_o, 0);
    checkOutput("asyncResetReady", ready_o, 1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 8'h7F, 12'b01_0000000_101, 0, 0, 1, 16'h3F81, 0, 0, 1);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
